// File: rtl/wr_full_afull.sv
// Write-side pointer and flag logic for an asynchronous FIFO: binary/Gray write pointer,
// occupancy against the synchronised read pointer, full/almost-full and sticky overflow.
module wr_full_afull #(
    parameter int ADDR_SIZE    = 4,
    parameter int AFULL_THRESH = (1 << ADDR_SIZE) - 2
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic                 wr_inc,
    input  logic [ADDR_SIZE:0]   wr_q2_rptr,
    input  logic                 wr_ovf_clr,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [ADDR_SIZE:0]   wr_ptr,
    output logic                 wr_full,
    output logic                 wr_afull,
    output logic [ADDR_SIZE:0]   wr_level,
    output logic                 wr_ovf,
    output logic                 wr_en
);

    localparam logic [ADDR_SIZE:0] AFULL_LVL = AFULL_THRESH[ADDR_SIZE:0];

    logic [ADDR_SIZE:0] wr_bin;
    logic [ADDR_SIZE:0] wr_bin_next;
    logic [ADDR_SIZE:0] wr_gray_next;
    logic [ADDR_SIZE:0] rd_bin;
    logic [ADDR_SIZE:0] level_next;
    logic               full_next;
    logic               afull_next;
    logic               ovf_next;

    assign wr_en        = wr_inc & ~wr_full;
    assign wr_addr      = wr_bin[ADDR_SIZE-1:0];
    assign wr_bin_next  = wr_bin + {{ADDR_SIZE{1'b0}}, wr_en};
    assign wr_gray_next = (wr_bin_next >> 1) ^ wr_bin_next;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rd_bin = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) begin
            rd_bin[i] = ^(wr_q2_rptr >> i);
        end
    end

    assign level_next = wr_bin_next - rd_bin;
    assign full_next  = (wr_gray_next ==
                         {~wr_q2_rptr[ADDR_SIZE:ADDR_SIZE-1], wr_q2_rptr[ADDR_SIZE-2:0]});
    assign afull_next = (level_next >= AFULL_LVL);
    assign ovf_next   = (wr_inc & wr_full) | (wr_ovf & ~wr_ovf_clr);

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            wr_bin   <= '0;
            wr_ptr   <= '0;
            wr_full  <= 1'b0;
            wr_afull <= 1'b0;
            wr_level <= '0;
            wr_ovf   <= 1'b0;
        end else begin
            wr_bin   <= wr_bin_next;
            wr_ptr   <= wr_gray_next;
            wr_full  <= full_next;
            wr_afull <= afull_next;
            wr_level <= level_next;
            wr_ovf   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_wr_full_afull.sv
// Self-checking bench for wr_full_afull: occupancy model driven by counts of accepted
// writes and read-pointer position, compared every cycle, plus directed literal checks.
module tb_wr_full_afull;

    logic       wr_clk = 1'b0;
    logic       wr_rst;
    logic       wr_inc;
    logic       wr_ovf_clr;
    logic [4:0] rd_count;
    logic [4:0] wr_q2_rptr;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr;
    logic       wr_full;
    logic       wr_afull;
    logic [4:0] wr_level;
    logic       wr_ovf;
    logic       wr_en;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    int m_wcount;
    int m_level;
    bit m_full;
    bit m_afull;
    bit m_ovf;

    always #5 wr_clk = ~wr_clk;

    function automatic logic [4:0] toGray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    assign wr_q2_rptr = toGray(rd_count);

    wr_full_afull #(.ADDR_SIZE(4), .AFULL_THRESH(14)) dut (
        .wr_clk    (wr_clk),
        .wr_rst    (wr_rst),
        .wr_inc    (wr_inc),
        .wr_q2_rptr(wr_q2_rptr),
        .wr_ovf_clr(wr_ovf_clr),
        .wr_addr   (wr_addr),
        .wr_ptr    (wr_ptr),
        .wr_full   (wr_full),
        .wr_afull  (wr_afull),
        .wr_level  (wr_level),
        .wr_ovf    (wr_ovf),
        .wr_en     (wr_en)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Occupancy model: writes accepted only while not full, level is writes minus reads mod 32.
    always @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            m_wcount = 0;
            m_level  = 0;
            m_full   = 0;
            m_afull  = 0;
            m_ovf    = 0;
        end else begin
            if (wr_inc && m_full)   m_ovf = 1;
            else if (wr_ovf_clr)    m_ovf = 0;
            if (wr_inc && !m_full)  m_wcount = (m_wcount + 1) % 32;
            m_level = (m_wcount - int'(rd_count)) & 31;
            m_full  = (m_level == 16);
            m_afull = (m_level >= 14);
        end
    end

    always @(posedge wr_clk) begin
        #2;
        if (wr_rst && chk_en) begin
            checkOutput("addr",  32'(wr_addr),  32'(m_wcount % 16));
            checkOutput("ptr",   32'(wr_ptr),   32'(toGray(5'(m_wcount))));
            checkOutput("level", 32'(wr_level), 32'(m_level));
            checkOutput("full",  32'(wr_full),  32'(m_full));
            checkOutput("afull", 32'(wr_afull), 32'(m_afull));
            checkOutput("ovf",   32'(wr_ovf),   32'(m_ovf));
            checkOutput("en",    32'(wr_en),    32'(wr_inc & ~m_full));
        end
    end

    task automatic applyStimulus(input logic inc, input logic clr, input logic [4:0] rd);
        @(negedge wr_clk);
        wr_inc     = inc;
        wr_ovf_clr = clr;
        rd_count   = rd;
        @(posedge wr_clk);
        #3;
    endtask

    task automatic doReset();
        @(negedge wr_clk);
        wr_inc     = 1'b0;
        wr_ovf_clr = 1'b0;
        rd_count   = '0;
        wr_rst     = 1'b0;
        @(negedge wr_clk);
        wr_rst = 1'b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_addr"},  32'(wr_addr),  0);
        checkOutput({tag, "_ptr"},   32'(wr_ptr),   0);
        checkOutput({tag, "_full"},  32'(wr_full),  0);
        checkOutput({tag, "_afull"}, 32'(wr_afull), 0);
        checkOutput({tag, "_level"}, 32'(wr_level), 0);
        checkOutput({tag, "_ovf"},   32'(wr_ovf),   0);
    endtask

    initial begin
        wr_rst     = 1'b0;
        wr_inc     = 1'b0;
        wr_ovf_clr = 1'b0;
        rd_count   = '0;
        #1;
        checkAllZero("reset");
        repeat (2) @(negedge wr_clk);
        wr_rst = 1'b1;
        chk_en = 1'b1;

        // Fill to full
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 1'b0, 5'd0);
            if (i == 13) checkOutput("fill_afull13", 32'(wr_afull), 0);
            if (i == 14) checkOutput("fill_afull14", 32'(wr_afull), 1);
            if (i == 15) checkOutput("fill_full15",  32'(wr_full),  0);
        end
        checkOutput("fill_full",  32'(wr_full),  1);
        checkOutput("fill_level", 32'(wr_level), 16);
        checkOutput("fill_ptr",   32'(wr_ptr),   32'h18);
        checkOutput("fill_addr",  32'(wr_addr),  0);

        // Overflow while full, clear, then set-wins-over-clear
        applyStimulus(1'b1, 1'b0, 5'd0);
        checkOutput("ovf_set",  32'(wr_ovf),  1);
        checkOutput("ovf_addr", 32'(wr_addr), 0);
        checkOutput("ovf_ptr",  32'(wr_ptr),  32'h18);
        applyStimulus(1'b0, 1'b1, 5'd0);
        checkOutput("ovf_clr", 32'(wr_ovf), 0);
        applyStimulus(1'b1, 1'b1, 5'd0);
        checkOutput("ovf_setwins", 32'(wr_ovf), 1);
        applyStimulus(1'b0, 1'b1, 5'd0);
        checkOutput("ovf_clr2", 32'(wr_ovf), 0);

        // Release by read pointer advance
        applyStimulus(1'b0, 1'b0, 5'd1);
        checkOutput("rel_full",  32'(wr_full),  0);
        checkOutput("rel_level", 32'(wr_level), 15);
        checkOutput("rel_afull", 32'(wr_afull), 1);

        // Simultaneous write and read advance at level 14
        applyStimulus(1'b0, 1'b0, 5'd2);
        checkOutput("sim_pre_level", 32'(wr_level), 14);
        applyStimulus(1'b1, 1'b0, 5'd3);
        checkOutput("sim_level", 32'(wr_level), 14);
        checkOutput("sim_afull", 32'(wr_afull), 1);
        checkOutput("sim_full",  32'(wr_full),  0);
        checkOutput("sim_ptr",   32'(wr_ptr),   32'h19);
        checkOutput("sim_addr",  32'(wr_addr),  1);

        // Wrap with read pointer trailing by one write
        doReset();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b0, 5'(i));
            if (wr_full !== 1'b0 || wr_level > 5'd1) begin
                checkOutput("wrap_bound", {wr_full, 26'd0, wr_level}, 32'd1);
            end
        end
        checkOutput("wrap_addr",  32'(wr_addr),  8);
        checkOutput("wrap_ptr",   32'(wr_ptr),   32'h0C);
        checkOutput("wrap_level", 32'(wr_level), 1);

        // Mid-run reset at level 9, no clock edge needed
        doReset();
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 5'd0);
        checkOutput("mid_level", 32'(wr_level), 9);
        wr_inc = 1'b0;
        wr_rst = 1'b0;
        #1;
        checkAllZero("midrst");
        checkOutput("midrst_en", 32'(wr_en), 0);
        @(negedge wr_clk);
        wr_rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 5'd0);
        checkOutput("post_addr",  32'(wr_addr),  1);
        checkOutput("post_ptr",   32'(wr_ptr),   1);
        checkOutput("post_level", 32'(wr_level), 1);
        applyStimulus(1'b0, 1'b0, 5'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
